// File: rtl/ifq_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ifq_if                                                        |
// | Brief    : Fetch-side and decode-side handshake bundle of the fetch queue |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
interface ifq_if #(
  parameter int DEPTH = 4
);
  localparam int PTR_W = $clog2(DEPTH);

  logic          pipe_flush;
  logic [63:0]   if_ifq_pc;
  logic [31:0]   if_ifq_instr;
  logic          if_ifq_bp;
  logic [63:0]   if_ifq_bt;
  logic          if_ifq_valid;
  logic          if_ifq_ready;
  logic [63:0]   ifq_dec_pc;
  logic [31:0]   ifq_dec_instr;
  logic          ifq_dec_bp;
  logic [63:0]   ifq_dec_bt;
  logic          ifq_dec_valid;
  logic          ifq_dec_ready;
  logic [PTR_W:0] ifq_count;

  // Drives fetch data, flush and decode ready; observes the queue outputs.
  modport master (
    output pipe_flush, if_ifq_pc, if_ifq_instr, if_ifq_bp, if_ifq_bt,
           if_ifq_valid, ifq_dec_ready,
    input  if_ifq_ready, ifq_dec_pc, ifq_dec_instr, ifq_dec_bp, ifq_dec_bt,
           ifq_dec_valid, ifq_count
  );

  modport slave (
    input  pipe_flush, if_ifq_pc, if_ifq_instr, if_ifq_bp, if_ifq_bt,
           if_ifq_valid, ifq_dec_ready,
    output if_ifq_ready, ifq_dec_pc, ifq_dec_instr, ifq_dec_bp, ifq_dec_bt,
           ifq_dec_valid, ifq_count
  );
endinterface
`default_nettype wire

// File: rtl/ifq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ifq                                                           |
// | Brief    : Instruction fetch queue, circular buffer between fetch/decode  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module ifq #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  ifq_if.slave bus
);
  localparam int             PTR_W  = $clog2(DEPTH);
  localparam logic [PTR_W:0] C_FULL = (PTR_W + 1)'(DEPTH);

  logic [63:0]      r_pc_mem    [DEPTH];
  logic [31:0]      r_instr_mem [DEPTH];
  logic             r_bp_mem    [DEPTH];
  logic [63:0]      r_bt_mem    [DEPTH];

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;

  logic w_ready;
  logic w_valid;
  logic w_enq;
  logic w_deq;

  // Handshake flags come only from the registered count, so neither side
  // sees a combinational path from the other.
  assign w_ready = (r_count != C_FULL);
  assign w_valid = (r_count != '0);
  assign w_enq   = bus.if_ifq_valid & w_ready & ~bus.pipe_flush;
  assign w_deq   = w_valid & bus.ifq_dec_ready & ~bus.pipe_flush;

  assign bus.if_ifq_ready  = w_ready;
  assign bus.ifq_dec_valid = w_valid;
  assign bus.ifq_count     = r_count;
  assign bus.ifq_dec_pc    = r_pc_mem[r_rd_ptr];
  assign bus.ifq_dec_instr = r_instr_mem[r_rd_ptr];
  assign bus.ifq_dec_bp    = r_bp_mem[r_rd_ptr];
  assign bus.ifq_dec_bt    = r_bt_mem[r_rd_ptr];

  // Storage carries no reset; the head is don't-care while valid is low.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_pc_mem[r_wr_ptr]    <= bus.if_ifq_pc;
      r_instr_mem[r_wr_ptr] <= bus.if_ifq_instr;
      r_bp_mem[r_wr_ptr]    <= bus.if_ifq_bp;
      r_bt_mem[r_wr_ptr]    <= bus.if_ifq_bt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || bus.pipe_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_enq) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_deq) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
        2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_ifq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_ifq                                                        |
// | Brief    : Directed vector table, corner sequences and random model check |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_ifq;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  ifq_if #(.DEPTH(DEPTH)) bus ();

  ifq #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic        r;
    logic        f;
    logic [63:0] pc;
    int          cnt;
    logic        vld;
    logic        rdy;
    logic [63:0] hpc;
  } vec_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        bp;
    logic [63:0] bt;
  } ent_t;

  vec_t tbl[$];
  ent_t mq[$];

  // Directed rows carry metadata derived from the PC so the head check covers all fields.
  function automatic logic [31:0] instr_of(input logic [63:0] pc);
    return {pc[15:0], 16'h0013};
  endfunction
  function automatic logic bp_of(input logic [63:0] pc);
    return pc[2];
  endfunction
  function automatic logic [63:0] bt_of(input logic [63:0] pc);
    return pc + 64'h2000;
  endfunction

  function automatic vec_t mk(input logic v, input logic r, input logic f,
                              input logic [63:0] pc, input int cnt,
                              input logic vld, input logic rdy,
                              input logic [63:0] hpc);
    vec_t t;
    t.v = v; t.r = r; t.f = f; t.pc = pc; t.cnt = cnt;
    t.vld = vld; t.rdy = rdy; t.hpc = hpc;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic r, input logic f, input logic [63:0] pc);
    bus.if_ifq_valid  = v;
    bus.ifq_dec_ready = r;
    bus.pipe_flush    = f;
    bus.if_ifq_pc     = pc;
    bus.if_ifq_instr  = instr_of(pc);
    bus.if_ifq_bp     = bp_of(pc);
    bus.if_ifq_bt     = bt_of(pc);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input int cnt, input logic vld,
                           input logic rdy, input logic [63:0] hpc);
    chk({tag, " count"}, 64'(bus.ifq_count), 64'(cnt));
    chk({tag, " valid"}, 64'(bus.ifq_dec_valid), 64'(vld));
    chk({tag, " ready"}, 64'(bus.if_ifq_ready), 64'(rdy));
    if (vld) begin
      chk({tag, " pc"}, bus.ifq_dec_pc, hpc);
      chk({tag, " instr"}, 64'(bus.ifq_dec_instr), 64'(instr_of(hpc)));
      chk({tag, " bp"}, 64'(bus.ifq_dec_bp), 64'(bp_of(hpc)));
      chk({tag, " bt"}, bus.ifq_dec_bt, bt_of(hpc));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 64'h0);
    cycle();
    cycle();
    chk_state("reset", 0, 1'b0, 1'b1, 64'h0);
    rst_n = 1'b1;

    // v r f pc -> count valid ready head_pc (state after the edge)
    tbl.push_back(mk(1, 0, 0, 64'h8000_0000, 1, 1, 1, 64'h8000_0000));
    tbl.push_back(mk(0, 1, 0, 64'h0,         0, 0, 1, 64'h0));
    tbl.push_back(mk(1, 0, 0, 64'h1000,      1, 1, 1, 64'h1000));
    tbl.push_back(mk(1, 0, 0, 64'h1004,      2, 1, 1, 64'h1000));
    tbl.push_back(mk(1, 0, 0, 64'h1008,      3, 1, 1, 64'h1000));
    tbl.push_back(mk(1, 0, 0, 64'h100C,      4, 1, 0, 64'h1000));
    tbl.push_back(mk(1, 0, 0, 64'h1010,      4, 1, 0, 64'h1000));
    tbl.push_back(mk(0, 1, 0, 64'h0,         3, 1, 1, 64'h1004));
    tbl.push_back(mk(0, 1, 0, 64'h0,         2, 1, 1, 64'h1008));
    tbl.push_back(mk(0, 1, 0, 64'h0,         1, 1, 1, 64'h100C));
    tbl.push_back(mk(0, 1, 0, 64'h0,         0, 0, 1, 64'h0));
    tbl.push_back(mk(1, 0, 0, 64'h2000,      1, 1, 1, 64'h2000));
    tbl.push_back(mk(1, 0, 0, 64'h2004,      2, 1, 1, 64'h2000));
    tbl.push_back(mk(1, 0, 0, 64'h2008,      3, 1, 1, 64'h2000));
    tbl.push_back(mk(1, 0, 0, 64'h200C,      4, 1, 0, 64'h2000));
    tbl.push_back(mk(1, 1, 0, 64'h2010,      3, 1, 1, 64'h2004));
    tbl.push_back(mk(1, 1, 0, 64'h2014,      3, 1, 1, 64'h2008));
    tbl.push_back(mk(1, 1, 0, 64'h2018,      3, 1, 1, 64'h200C));
    tbl.push_back(mk(1, 1, 0, 64'h201C,      3, 1, 1, 64'h2014));
    tbl.push_back(mk(1, 1, 1, 64'h2020,      0, 0, 1, 64'h0));
    tbl.push_back(mk(1, 0, 0, 64'h3000,      1, 1, 1, 64'h3000));
    tbl.push_back(mk(0, 1, 0, 64'h0,         0, 0, 1, 64'h0));

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].r, tbl[i].f, tbl[i].pc);
      cycle();
      chk_state($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].vld, tbl[i].rdy, tbl[i].hpc);
    end

    // Full-rate streaming: the head is always the instruction of the previous edge.
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b1, 1'b0, 64'h4000 + 64'(4 * i));
      cycle();
      chk_state($sformatf("stream%0d", i), 1, 1'b1, 1'b1, 64'h4000 + 64'(4 * i));
    end
    drive(1'b0, 1'b1, 1'b0, 64'h0);
    cycle();
    chk_state("stream_end", 0, 1'b0, 1'b1, 64'h0);

    // Reset in the middle of traffic discards queued entries and the offered one.
    drive(1'b1, 1'b0, 1'b0, 64'h5000);
    cycle();
    drive(1'b1, 1'b0, 1'b0, 64'h5004);
    cycle();
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 64'h5008);
    cycle();
    chk_state("midreset", 0, 1'b0, 1'b1, 64'h0);
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 64'h6000);
    cycle();
    chk_state("post_reset", 1, 1'b1, 1'b1, 64'h6000);
    drive(1'b0, 1'b0, 1'b1, 64'h0);
    cycle();

    // Random traffic against a reference queue.
    mq.delete();
    for (int i = 0; i < 10000; i++) begin
      ent_t e;
      logic v, r, f, enq, deq;
      v = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      f = ($urandom_range(0, 99) < 5);
      e.pc    = {$urandom, $urandom};
      e.instr = $urandom;
      e.bp    = 1'($urandom_range(0, 1));
      e.bt    = {$urandom, $urandom};
      bus.if_ifq_valid  = v;
      bus.ifq_dec_ready = r;
      bus.pipe_flush    = f;
      bus.if_ifq_pc     = e.pc;
      bus.if_ifq_instr  = e.instr;
      bus.if_ifq_bp     = e.bp;
      bus.if_ifq_bt     = e.bt;
      enq = v && (mq.size() != DEPTH) && !f;
      deq = r && (mq.size() != 0) && !f;
      cycle();
      if (f) mq.delete();
      else begin
        if (deq) void'(mq.pop_front());
        if (enq) mq.push_back(e);
      end
      chk("rnd count", 64'(bus.ifq_count), 64'(mq.size()));
      chk("rnd valid", 64'(bus.ifq_dec_valid), 64'(mq.size() != 0));
      chk("rnd ready", 64'(bus.if_ifq_ready), 64'(mq.size() != DEPTH));
      if (mq.size() != 0) begin
        chk("rnd head", {bus.ifq_dec_pc, bus.ifq_dec_instr, bus.ifq_dec_bp, bus.ifq_dec_bt} == mq[0] ? 64'd1 : 64'd0, 64'd1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
